// File: rtl/mixcol_sched_if.sv
// mixcol_sched_if
//   Groups the input and output valid/ready handshakes of the MixColumns
//   sequencer into one bundle.
//
//   Signals:
//     in_valid   producer -> sched   in_state is valid
//     in_ready   sched -> producer   sequencer can accept a state
//     in_state   producer -> sched   128-bit AES state (column 0 in [127:96])
//     out_valid  sched -> consumer   out_state is valid
//     out_ready  consumer -> sched   consumer accepts out_state
//     out_state  sched -> consumer   mixed 128-bit state
//     busy       sched -> monitor    transform in progress or result pending
//     bypass     producer -> sched   only with MIXCOL_BYPASS_EN: skip mixing
//
//   Modports: slave = the sequencer, master = producer/consumer side.
interface mixcol_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef MIXCOL_BYPASS_EN
  logic         bypass;
`endif

  modport slave (
`ifdef MIXCOL_BYPASS_EN
    input  bypass,
`endif
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state,
    output busy
  );

  modport master (
`ifdef MIXCOL_BYPASS_EN
    output bypass,
`endif
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  busy
  );
endinterface

// File: rtl/mixcol_sched.sv
// mixcol_sched
//   AES encryption MixColumns sequencer. Accepts a 128-bit state, mixes one
//   column per cycle through four shared GF(2^8) doubling units and returns
//   the mixed state. Latency from accept edge to out_valid is 4 edges.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   mixcol_sched_if.slave: in_valid/in_ready/in_state,
//           out_valid/out_ready/out_state, busy (and bypass, see below)
//
//   Optional feature: define MIXCOL_BYPASS_EN to add the bypass input. A state
//   accepted with bypass=1 is forwarded unmixed (final AES round), with
//   out_valid high one edge after the accept.

// Multiply a byte by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
module lut_mult_2 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign y = xtime(a);
endmodule

module mixcol_sched #(
  parameter int NUM_COLS = 4
) (
  input  logic          clk,
  input  logic          rst,
  mixcol_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  state_t       state;
  state_t       state_next;
  logic [1:0]   col_cnt;
  logic [127:0] st;          // state latched at the input handshake
  logic [127:0] out_state_q;
  logic [127:0] out_next;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         accept;
  logic         out_fire;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   a [4];
  logic [7:0]   x [4];

  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign bus.busy      = busy_q;

  // Select the active column from the latched state.
  always_comb begin
    col_in = st[127:96];
    case (col_cnt)
      2'd0:    col_in = st[127:96];
      2'd1:    col_in = st[95:64];
      2'd2:    col_in = st[63:32];
      2'd3:    col_in = st[31:0];
      default: col_in = st[127:96];
    endcase
  end

  // Shared doubling units and the per-row mix: b_r = 2a_r ^ 3a_{r+1} ^ a_{r+2} ^ a_{r+3}.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_in[31-8*r -: 8];
    lut_mult_2 u_mul2 (.a(a[r]), .y(x[r]));
    assign col_out[31-8*r -: 8] = x[r] ^ x[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
  end

  // Merge the freshly mixed column into the output state at col_cnt.
  always_comb begin
    out_next = out_state_q;
    case (col_cnt)
      2'd0:    out_next[127:96] = col_out;
      2'd1:    out_next[95:64]  = col_out;
      2'd2:    out_next[63:32]  = col_out;
      2'd3:    out_next[31:0]   = col_out;
      default: out_next         = out_state_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MIXCOL_BYPASS_EN
          if (bus.bypass) state_next = DONE;
          else            state_next = COL;
`else
          state_next = COL;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      COL: begin
        if (col_cnt == LAST_COL) state_next = DONE;
        else                     state_next = COL;
      end
      DONE: begin
        if (out_fire) state_next = IDLE;
        else          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
      busy_q      <= (state_next != IDLE);
    end
  end

  // Datapath: input latch, column counter and output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= 128'h0;
      out_state_q <= 128'h0;
      col_cnt     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            st      <= bus.in_state;
            col_cnt <= 2'd0;
`ifdef MIXCOL_BYPASS_EN
            if (bus.bypass) out_state_q <= bus.in_state;
`endif
          end
        end
        COL: begin
          out_state_q <= out_next;
          col_cnt     <= col_cnt + 2'd1;
        end
        default: begin
          col_cnt <= col_cnt;
        end
      endcase
    end
  end
endmodule
